// File: rtl/opb_register_ppc2simulink_hs.sv
// OPB slave mailbox: PPC writes a DATA word that a downstream consumer drains with a valid/ready handshake.
// Define OPB_REG_STATUS_EN to add the STATUS register with its saturating overwrite counter.
module opb_register_ppc2simulink_hs #(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h00000000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [31:0]             user_data_out,
  output logic                    user_valid,
  input  logic                    user_ready
);

  logic                    w_hit;
  logic                    w_is_status;
  logic                    w_ack_now;
  logic                    w_wr_data;
  logic [31:0]             w_status;
  logic [31:0]             w_rdata;
  logic [1:0]              w_unused;

  logic                    r_ack;
  logic                    r_busy;
  logic [0:C_OPB_DWIDTH-1] r_sl_dbus;
  logic [31:0]             r_data;
  logic                    r_pending;

  assign w_unused    = {OPB_seqAddr, (C_FAMILY == "")};

  assign w_hit       = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_is_status = OPB_ABus[C_OPB_AWIDTH-3];
  // r_busy remembers that this select assertion was already acked
  assign w_ack_now   = w_hit && !r_busy;
  assign w_wr_data   = r_ack && OPB_select && !OPB_RNW && !w_is_status;
  assign w_rdata     = w_is_status ? w_status : r_data;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_sl_dbus <= '0;
    end else begin
      r_ack     <= w_ack_now;
      r_busy    <= OPB_select && (r_busy || w_ack_now);
      r_sl_dbus <= (w_ack_now && OPB_RNW) ? w_rdata : '0;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_data    <= '0;
      r_pending <= 1'b0;
    end else if (w_wr_data) begin
      for (int b = 0; b < 4; b++) begin
        if (OPB_BE[b]) r_data[31-8*b -: 8] <= OPB_DBus[8*b +: 8];
      end
      r_pending <= 1'b1;
    end else if (r_pending && user_ready) begin
      r_pending <= 1'b0;
    end
  end

`ifdef OPB_REG_STATUS_EN
  logic       w_wr_status;
  logic [7:0] r_ovf_cnt;

  assign w_wr_status = r_ack && OPB_select && !OPB_RNW && w_is_status;

  // A write landing on unconsumed data counts as an overwrite unless the consumer takes it the same cycle
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_ovf_cnt <= '0;
    end else if (w_wr_status) begin
      r_ovf_cnt <= '0;
    end else if (w_wr_data && r_pending && !user_ready && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign w_status = {r_pending, 23'd0, r_ovf_cnt};
`else
  assign w_status = '0;
`endif

  assign Sl_DBus       = r_sl_dbus;
  assign Sl_xferAck    = r_ack;
  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;
  assign user_data_out = r_data;
  assign user_valid    = r_pending;

endmodule
